bcd_minus_bcd_seq: RTL and testbench

Digit-serial 2-digit BCD subtractor. It is the inverse-direction companion to the combinational 2-digit BCD adder. It computes (tens1:ones1) − (tens2:ones2) − Bin one decimal digit per clock, ones digit first, and returns a ten's-complement result with a borrow out. A start/busy/done handshake lets it sit behind a register-based operand source, such as a keypad or a counter front-end.

---
 rtl/bcd_pkg.sv | 7 +
 rtl/bcd_digit_sub.sv | 19 +
 rtl/bcd_minus_bcd_seq.sv | 111 +++++++++++
 tb/tb_bcd_minus_bcd_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared digit width, radix and sequencer state type for the BCD subtractor
package bcd_pkg;
  localparam int BCD_W     = 4;
  localparam int BCD_RADIX = 10;

  typedef enum logic [1:0] {IDLE, ONES, TENS, DONE} state_t;
endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - one BCD digit of a - b - bin with ten's-complement correction
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
);
  logic [BCD_W:0] diff;

  // The extra MSB acts as a sign bit: every 4-bit a - b - bin fits in 5-bit signed.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, bin};
    bout = diff[BCD_W];
    d    = bout ? (diff[BCD_W-1:0] + BCD_W'(BCD_RADIX)) : diff[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_minus_bcd_seq.sv
// rtl/bcd_minus_bcd_seq.sv - digit-serial 2-digit BCD subtractor; BCD_SUB_INVALID_DETECT_EN adds err
module bcd_minus_bcd_seq
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BCD_W-1:0] ones1,
  input  logic [BCD_W-1:0] tens1,
  input  logic [BCD_W-1:0] ones2,
  input  logic [BCD_W-1:0] tens2,
  input  logic             Bin,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef BCD_SUB_INVALID_DETECT_EN
  ,
  output logic             err
`endif
);
  state_t           state, state_n;
  logic             accept;
  logic [BCD_W-1:0] o1_q, t1_q, o2_q, t2_q;
  logic             bin_q, b_q;
  logic [BCD_W-1:0] a_sel, b_sel, d;
  logic             c_sel, bout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = ONES;
      end
      ONES: state_n = TENS;
      TENS: state_n = DONE;
      DONE: begin
        accept  = start;
        state_n = start ? ONES : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == ONES) || (state == TENS);
  assign done = (state == DONE);

  // One digit subtractor shared by both steps; the tens step uses the ones-step borrow.
  assign a_sel = (state == TENS) ? t1_q : o1_q;
  assign b_sel = (state == TENS) ? t2_q : o2_q;
  assign c_sel = (state == TENS) ? b_q  : bin_q;

  bcd_digit_sub u_digit (
    .a    (a_sel),
    .b    (b_sel),
    .bin  (c_sel),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o1_q  <= '0;
      t1_q  <= '0;
      o2_q  <= '0;
      t2_q  <= '0;
      bin_q <= 1'b0;
      b_q   <= 1'b0;
      ones  <= '0;
      tens  <= '0;
      Bout  <= 1'b0;
    end else begin
      if (accept) begin
        o1_q  <= ones1;
        t1_q  <= tens1;
        o2_q  <= ones2;
        t2_q  <= tens2;
        bin_q <= Bin;
      end
      if (state == ONES) begin
        ones <= d;
        b_q  <= bout;
      end
      if (state == TENS) begin
        tens <= d;
        Bout <= bout;
      end
    end
  end

`ifdef BCD_SUB_INVALID_DETECT_EN
  logic invalid;
  assign invalid = (o1_q > BCD_W'(BCD_RADIX - 1)) || (t1_q > BCD_W'(BCD_RADIX - 1)) ||
                   (o2_q > BCD_W'(BCD_RADIX - 1)) || (t2_q > BCD_W'(BCD_RADIX - 1));

  // Raised on entry to DONE, held until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)                 err <= 1'b0;
    else if (accept)         err <= 1'b0;
    else if (state == TENS)  err <= invalid;
  end
`endif
endmodule

// File: tb/tb_bcd_minus_bcd_seq.sv
// tb/tb_bcd_minus_bcd_seq.sv - directed bench with decimal-arithmetic scoreboard for bcd_minus_bcd_seq
module tb_bcd_minus_bcd_seq;
  logic       clk = 1'b0;
  logic       rst, start, Bin;
  logic [3:0] ones1, tens1, ones2, tens2;
  logic [3:0] ones, tens;
  logic       Bout, busy, done;
`ifdef BCD_SUB_INVALID_DETECT_EN
  logic       err;
`endif

  bcd_minus_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ones1 (ones1),
    .tens1 (tens1),
    .ones2 (ones2),
    .tens2 (tens2),
    .Bin   (Bin),
    .ones  (ones),
    .tens  (tens),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef BCD_SUB_INVALID_DETECT_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int o;
    int t;
    int bo;
    int chk;
    int er;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // Whole-number decimal subtraction; result wraps to the 100's complement when negative.
  function automatic exp_t model(input int c, input int t1, input int o1,
                                 input int t2, input int o2, input int b);
    exp_t e;
    int v;
    v     = (t1 * 10 + o1) - (t2 * 10 + o2) - b;
    e.c   = c;
    e.bo  = (v < 0) ? 1 : 0;
    if (v < 0) v += 100;
    e.t   = v / 10;
    e.o   = v % 10;
    e.er  = (t1 > 9 || o1 > 9 || t2 > 9 || o2 > 9) ? 1 : 0;
    e.chk = !e.er;
    return e;
  endfunction

  task automatic issue(input int t1, input int o1, input int t2, input int o2, input int b);
    tens1 = 4'(t1);
    ones1 = 4'(o1);
    tens2 = 4'(t2);
    ones2 = 4'(o2);
    Bin   = b[0];
    start = 1'b1;
    q.push_back(model(cyc + 3, t1, o1, t2, o2, b));
  endtask

  task automatic wait_done(input string nm, input int c0, input int et, input int eo, input int eb);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check({nm, "_done"}, int'(done), 1);
    check({nm, "_latency"}, cyc - c0, 3);
    check({nm, "_tens"}, int'(tens), et);
    check({nm, "_ones"}, int'(ones), eo);
    check({nm, "_bout"}, int'(Bout), eb);
  endtask

  always @(negedge clk) begin : cmp
    int eb, ed;
    if (cyc >= 2) begin
      eb = (q.size() > 0 && (cyc == q[0].c - 2 || cyc == q[0].c - 1)) ? 1 : 0;
      ed = (q.size() > 0 && cyc == q[0].c) ? 1 : 0;
      check("busy", int'(busy), eb);
      check("done", int'(done), ed);
      if (ed == 1) begin
        if (q[0].chk != 0) begin
          check("model_tens", int'(tens), q[0].t);
          check("model_ones", int'(ones), q[0].o);
          check("model_bout", int'(Bout), q[0].bo);
        end
`ifdef BCD_SUB_INVALID_DETECT_EN
        check("model_err", int'(err), q[0].er);
`endif
        void'(q.pop_front());
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; Bin = 1'b0;
    ones1 = '0; tens1 = '0; ones2 = '0; tens2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ones", int'(ones), 0);
    check("rst_tens", int'(tens), 0);
    check("rst_bout", int'(Bout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;

    @(negedge clk); c0 = cyc; issue(4, 5, 2, 3, 0);
    @(negedge clk); start = 1'b0;
    wait_done("45m23", c0, 2, 2, 0);

    @(negedge clk); c0 = cyc; issue(2, 3, 4, 5, 0);
    @(negedge clk); start = 1'b0;
    wait_done("23m45", c0, 7, 8, 1);

    @(negedge clk); c0 = cyc; issue(5, 0, 0, 7, 1);
    @(negedge clk); start = 1'b0;
    wait_done("50m07b", c0, 4, 2, 0);

    // start held high through DONE: second operation begins straight from DONE
    @(negedge clk); c0 = cyc; issue(0, 0, 0, 0, 1);
    @(negedge clk); tens1 = 4'd9; ones1 = 4'd9; tens2 = 4'd9; ones2 = 4'd9; Bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_first_done", int'(done), 1);
    check("b2b_first_tens", int'(tens), 9);
    check("b2b_first_ones", int'(ones), 9);
    check("b2b_first_bout", int'(Bout), 1);
    q.push_back(model(cyc + 3, 9, 9, 9, 9, 0));
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_second_gap", cyc - c0, 6);
    check("b2b_second_tens", int'(tens), 0);
    check("b2b_second_ones", int'(ones), 0);
    check("b2b_second_bout", int'(Bout), 0);

    // start and new operands while busy must be ignored
    @(negedge clk); c0 = cyc; issue(4, 5, 2, 3, 0);
    @(negedge clk); tens1 = 4'd2; ones1 = 4'd3; tens2 = 4'd4; ones2 = 4'd5; Bin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_ign_done", int'(done), 1);
    check("busy_ign_tens", int'(tens), 2);
    check("busy_ign_ones", int'(ones), 2);
    check("busy_ign_bout", int'(Bout), 0);
    start = 1'b0;

    // reset while in TENS discards the operation
    @(negedge clk); c0 = cyc; issue(8, 8, 1, 1, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 q.delete();
    @(negedge clk);
    check("midrst_ones", int'(ones), 0);
    check("midrst_tens", int'(tens), 0);
    check("midrst_bout", int'(Bout), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", int'(done), 0);

    @(negedge clk); c0 = cyc; issue(1, 0, 0, 1, 0);
    @(negedge clk); start = 1'b0;
    wait_done("10m01", c0, 0, 9, 0);

`ifdef BCD_SUB_INVALID_DETECT_EN
    @(negedge clk); c0 = cyc; issue(0, 10, 0, 0, 0);
    @(negedge clk); start = 1'b0;
    wait_done("inv", c0, 0, 10, 0);
    check("inv_err", int'(err), 1);
    @(negedge clk); c0 = cyc; issue(3, 3, 1, 1, 0);
    @(negedge clk); start = 1'b0;
    wait_done("valid_after_inv", c0, 2, 2, 0);
    check("valid_err", int'(err), 0);
`endif

    repeat (3) @(negedge clk);
    check("pending_results", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
